// File: rtl/sdram_host_req.sv
// Host request front end: latches one read/write command, splits page-crossing bursts into two segments.
// Latency: host_ack the cycle after acceptance; sdram req the same cycle; req drops the cycle after ack is seen.
// Backpressure: one command at a time; host strobes are only honoured while host_ready is high.
module sdram_host_req #(
    parameter int BANK_W = 2,
    parameter int ROW_W  = 13,
    parameter int COL_W  = 9
) (
    input  logic                            clk_100m,
    input  logic                            rst_n,
    input  logic                            host_wr_req,
    input  logic                            host_rd_req,
    input  logic [BANK_W+ROW_W+COL_W-1:0]   host_addr,
    input  logic [COL_W-1:0]                host_len,
    output logic                            host_ready,
    output logic                            host_ack,
    output logic                            host_done,
    input  logic                            sdram_init_done,
    input  logic                            sdram_wr_ack,
    input  logic                            sdram_rd_ack,
    output logic                            sdram_wr_req,
    output logic                            sdram_rd_req,
    output logic [COL_W-1:0]                sdwr_bytes,
    output logic [COL_W-1:0]                sdrd_bytes,
    output logic [BANK_W-1:0]               sys_bank,
    output logic [ROW_W-1:0]                sys_row,
    output logic [COL_W-1:0]                sys_col
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_REQ, S_XFER, S_NEXT, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                rd_q, rd_d;        // 1 = read command, 0 = write command
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [COL_W-1:0]    seg_q, seg_d;      // words in the current segment
    logic [COL_W-1:0]    rem_q, rem_d;      // words left for the second segment
    logic                ack_q, ack_d;

    // Segment sizing is done one bit wider so a page-aligned start (room = 512) is representable.
    logic [COL_W:0]      room;
    logic [COL_W:0]      seg_calc;
    logic [COL_W-1:0]    in_col;
    logic                sel_ack;
    logic                seg_active;

    assign in_col   = host_addr[COL_W-1:0];
    assign room     = {1'b1, {COL_W{1'b0}}} - {1'b0, in_col};
    assign seg_calc = ({1'b0, host_len} < room) ? {1'b0, host_len} : room;
    assign sel_ack  = rd_q ? sdram_rd_ack : sdram_wr_ack;

    // Next-state and command/segment bookkeeping.
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        bank_d  = bank_q;
        row_d   = row_q;
        col_d   = col_q;
        seg_d   = seg_q;
        rem_d   = rem_q;
        ack_d   = 1'b0;
        case (state_q)
            S_INIT: begin
                if (sdram_init_done) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (host_rd_req || host_wr_req) begin
                    rd_d   = host_rd_req;   // read wins when both strobe together
                    bank_d = host_addr[BANK_W+ROW_W+COL_W-1 -: BANK_W];
                    row_d  = host_addr[ROW_W+COL_W-1 -: ROW_W];
                    col_d  = in_col;
                    ack_d  = 1'b1;
                    if (host_len == '0) begin
                        seg_d   = '0;
                        rem_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        seg_d   = seg_calc[COL_W-1:0];
                        rem_d   = host_len - seg_calc[COL_W-1:0];
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // The controller may refresh first; hold the request until it acks.
                if (sel_ack) state_d = S_XFER;
            end
            S_XFER: begin
                if (!sel_ack) state_d = (rem_q != '0) ? S_NEXT : S_DONE;
            end
            S_NEXT: begin
                // Second segment starts at column 0 of the following row (row carries into bank).
                col_d          = '0;
                {bank_d, row_d} = {bank_q, row_q} + (BANK_W+ROW_W)'(1);
                seg_d          = rem_q;
                rem_d          = '0;
                state_d        = S_REQ;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    // State and latched command registers.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            rd_q    <= 1'b0;
            bank_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            seg_q   <= '0;
            rem_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            bank_q  <= bank_d;
            row_q   <= row_d;
            col_q   <= col_d;
            seg_q   <= seg_d;
            rem_q   <= rem_d;
            ack_q   <= ack_d;
        end
    end

    assign seg_active   = (state_q == S_REQ) || (state_q == S_XFER);
    assign host_ready   = (state_q == S_IDLE);
    assign host_ack     = ack_q;
    assign host_done    = (state_q == S_DONE);
    assign sdram_rd_req = (state_q == S_REQ) &&  rd_q;
    assign sdram_wr_req = (state_q == S_REQ) && !rd_q;
    assign sdrd_bytes   = (seg_active &&  rd_q) ? seg_q : '0;
    assign sdwr_bytes   = (seg_active && !rd_q) ? seg_q : '0;
    assign sys_bank     = bank_q;
    assign sys_row      = row_q;
    assign sys_col      = col_q;

endmodule

// File: tb/tb_sdram_host_req.sv
module tb_sdram_host_req;

    logic        clk_100m = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_wr_req = 1'b0;
    logic        host_rd_req = 1'b0;
    logic [23:0] host_addr = '0;
    logic [8:0]  host_len = '0;
    logic        host_ready, host_ack, host_done;
    logic        sdram_init_done = 1'b0;
    logic        sdram_wr_ack = 1'b0;
    logic        sdram_rd_ack = 1'b0;
    logic        sdram_wr_req, sdram_rd_req;
    logic [8:0]  sdwr_bytes, sdrd_bytes;
    logic [1:0]  sys_bank;
    logic [12:0] sys_row;
    logic [8:0]  sys_col;

    int checks = 0;
    int failures = 0;

    sdram_host_req dut (
        .clk_100m        (clk_100m),
        .rst_n           (rst_n),
        .host_wr_req     (host_wr_req),
        .host_rd_req     (host_rd_req),
        .host_addr       (host_addr),
        .host_len        (host_len),
        .host_ready      (host_ready),
        .host_ack        (host_ack),
        .host_done       (host_done),
        .sdram_init_done (sdram_init_done),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_rd_ack    (sdram_rd_ack),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_rd_req    (sdram_rd_req),
        .sdwr_bytes      (sdwr_bytes),
        .sdrd_bytes      (sdrd_bytes),
        .sys_bank        (sys_bank),
        .sys_row         (sys_row),
        .sys_col         (sys_col)
    );

    always #5 clk_100m = ~clk_100m;

    // Advance one clock and settle 1 ns past the edge.
    task automatic step;
        @(posedge clk_100m);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) step;
        checks++;
        if ({host_ready, host_ack, host_done, sdram_wr_req, sdram_rd_req} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {host_ready, host_ack, host_done, sdram_wr_req, sdram_rd_req});
        end
        checks++;
        if ({sdwr_bytes, sdrd_bytes, sys_bank, sys_row, sys_col} !== 42'd0) begin
            failures++;
            $display("FAIL reset_data: got wr=%0d rd=%0d b=%0d r=%0h c=%0d want all 0",
                     sdwr_bytes, sdrd_bytes, sys_bank, sys_row, sys_col);
        end
        rst_n = 1'b1;
        step;
        checks++;
        if (host_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_init_ready: got %b want 0", host_ready);
        end
    endtask

    task automatic test_init;
        repeat (50) step;
        host_wr_req = 1'b1;
        host_len    = 9'd4;
        step;
        host_wr_req = 1'b0;
        step;
        checks++;
        if ({host_ready, host_ack, sdram_wr_req} !== 3'b000) begin
            failures++;
            $display("FAIL init_ignore: got ready/ack/wr=%b want 000",
                     {host_ready, host_ack, sdram_wr_req});
        end
        sdram_init_done = 1'b1;
        step;
        checks++;
        if ({host_ready, host_ack} !== 2'b10) begin
            failures++;
            $display("FAIL init_ready: got ready/ack=%b want 10", {host_ready, host_ack});
        end
    endtask

    task automatic test_write_inpage;
        host_wr_req = 1'b1;
        host_addr   = {2'd0, 13'd5, 9'd16};
        host_len    = 9'd32;
        step;
        host_wr_req = 1'b0;
        checks++;
        if ({host_ack, host_ready, sdram_wr_req, sdram_rd_req} !== 4'b1010) begin
            failures++;
            $display("FAIL wr_accept: got ack/ready/wr/rd=%b want 1010",
                     {host_ack, host_ready, sdram_wr_req, sdram_rd_req});
        end
        checks++;
        if (sdwr_bytes !== 9'd32 || sdrd_bytes !== 9'd0 || sys_col !== 9'd16 ||
            sys_row !== 13'd5 || sys_bank !== 2'd0) begin
            failures++;
            $display("FAIL wr_seg: got wrb=%0d rdb=%0d b=%0d r=%0d c=%0d want 32 0 0 5 16",
                     sdwr_bytes, sdrd_bytes, sys_bank, sys_row, sys_col);
        end
        // Controller busy (e.g. refreshing): request must be held.
        repeat (3) step;
        checks++;
        if ({host_ack, sdram_wr_req, sdwr_bytes} !== {1'b0, 1'b1, 9'd32}) begin
            failures++;
            $display("FAIL wr_hold: got ack=%b wr=%b bytes=%0d want 0 1 32",
                     host_ack, sdram_wr_req, sdwr_bytes);
        end
        sdram_wr_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step;
            checks++;
            if ({sdram_wr_req, host_done} !== 2'b00) begin
                failures++;
                $display("FAIL wr_ack_window[%0d]: got wr/done=%b want 00",
                         i, {sdram_wr_req, host_done});
            end
        end
        sdram_wr_ack = 1'b0;
        step;
        checks++;
        if (host_done !== 1'b1) begin
            failures++;
            $display("FAIL wr_done: got %b want 1", host_done);
        end
        step;
        checks++;
        if ({host_done, host_ready} !== 2'b01) begin
            failures++;
            $display("FAIL wr_done_pulse: got done/ready=%b want 01", {host_done, host_ready});
        end
    endtask

    task automatic test_read_split;
        host_rd_req = 1'b1;
        host_addr   = {2'd1, 13'h1FFF, 9'd500};
        host_len    = 9'd20;
        step;
        host_rd_req = 1'b0;
        checks++;
        if ({host_ack, sdram_rd_req, sdram_wr_req} !== 3'b110 || sdrd_bytes !== 9'd12 ||
            sdwr_bytes !== 9'd0 || {sys_bank, sys_row, sys_col} !== {2'd1, 13'h1FFF, 9'd500}) begin
            failures++;
            $display("FAIL split_seg1: got ack/rd/wr=%b rdb=%0d wrb=%0d b=%0d r=%0h c=%0d want 110 12 0 1 1fff 500",
                     {host_ack, sdram_rd_req, sdram_wr_req}, sdrd_bytes, sdwr_bytes,
                     sys_bank, sys_row, sys_col);
        end
        sdram_rd_ack = 1'b1;
        step;
        checks++;
        if (sdram_rd_req !== 1'b0) begin
            failures++;
            $display("FAIL split_req_drop: got %b want 0", sdram_rd_req);
        end
        sdram_rd_ack = 1'b0;
        step;
        step;
        checks++;
        if ({sdram_rd_req, host_done} !== 2'b10 || sdrd_bytes !== 9'd8 ||
            {sys_bank, sys_row, sys_col} !== {2'd2, 13'd0, 9'd0}) begin
            failures++;
            $display("FAIL split_seg2: got rd/done=%b rdb=%0d b=%0d r=%0h c=%0d want 10 8 2 0 0",
                     {sdram_rd_req, host_done}, sdrd_bytes, sys_bank, sys_row, sys_col);
        end
        sdram_rd_ack = 1'b1;
        step;
        sdram_rd_ack = 1'b0;
        step;
        checks++;
        if (host_done !== 1'b1) begin
            failures++;
            $display("FAIL split_done: got %b want 1", host_done);
        end
        step;
        checks++;
        if ({host_done, host_ready} !== 2'b01) begin
            failures++;
            $display("FAIL split_done_pulse: got done/ready=%b want 01", {host_done, host_ready});
        end
    endtask

    task automatic test_wrap;
        sdram_init_done = 1'b0;   // must have no effect once out of init
        host_wr_req = 1'b1;
        host_addr   = 24'hFFFFFF;
        host_len    = 9'd2;
        step;
        host_wr_req = 1'b0;
        checks++;
        if (sdram_wr_req !== 1'b1 || sdwr_bytes !== 9'd1 ||
            {sys_bank, sys_row, sys_col} !== {2'd3, 13'h1FFF, 9'd511}) begin
            failures++;
            $display("FAIL wrap_seg1: got wr=%b wrb=%0d b=%0d r=%0h c=%0d want 1 1 3 1fff 511",
                     sdram_wr_req, sdwr_bytes, sys_bank, sys_row, sys_col);
        end
        sdram_rd_ack = 1'b1;      // wrong-direction ack is ignored
        step;
        sdram_rd_ack = 1'b0;
        checks++;
        if (sdram_wr_req !== 1'b1) begin
            failures++;
            $display("FAIL wrap_wrong_ack: got wr=%b want 1", sdram_wr_req);
        end
        sdram_wr_ack = 1'b1;
        step;
        sdram_wr_ack = 1'b0;
        step;
        step;
        checks++;
        if (sdram_wr_req !== 1'b1 || sdwr_bytes !== 9'd1 ||
            {sys_bank, sys_row, sys_col} !== 24'd0) begin
            failures++;
            $display("FAIL wrap_seg2: got wr=%b wrb=%0d b=%0d r=%0h c=%0d want 1 1 0 0 0",
                     sdram_wr_req, sdwr_bytes, sys_bank, sys_row, sys_col);
        end
        sdram_wr_ack = 1'b1;
        step;
        sdram_wr_ack = 1'b0;
        step;
        checks++;
        if (host_done !== 1'b1) begin
            failures++;
            $display("FAIL wrap_done: got %b want 1", host_done);
        end
        step;
        checks++;
        if (host_ready !== 1'b1) begin
            failures++;
            $display("FAIL wrap_idle: got ready=%b want 1", host_ready);
        end
        sdram_init_done = 1'b1;
    endtask

    task automatic test_simul_and_zero;
        host_rd_req = 1'b1;
        host_wr_req = 1'b1;
        host_addr   = {2'd2, 13'd7, 9'd3};
        host_len    = 9'd4;
        step;
        host_rd_req = 1'b0;
        host_wr_req = 1'b0;
        checks++;
        if ({sdram_rd_req, sdram_wr_req} !== 2'b10 || sdrd_bytes !== 9'd4 || sdwr_bytes !== 9'd0) begin
            failures++;
            $display("FAIL simul_rd_wins: got rd/wr=%b rdb=%0d wrb=%0d want 10 4 0",
                     {sdram_rd_req, sdram_wr_req}, sdrd_bytes, sdwr_bytes);
        end
        host_wr_req = 1'b1;       // strobe while busy is dropped
        sdram_rd_ack = 1'b1;
        step;
        host_wr_req = 1'b0;
        sdram_rd_ack = 1'b0;
        step;
        step;
        checks++;
        if ({host_ready, host_ack, sdram_wr_req} !== 3'b100) begin
            failures++;
            $display("FAIL busy_strobe_dropped: got ready/ack/wr=%b want 100",
                     {host_ready, host_ack, sdram_wr_req});
        end
        host_rd_req = 1'b1;
        host_wr_req = 1'b1;
        host_len    = 9'd0;
        step;
        host_rd_req = 1'b0;
        host_wr_req = 1'b0;
        checks++;
        if ({host_ack, host_done, sdram_rd_req, sdram_wr_req} !== 4'b1100) begin
            failures++;
            $display("FAIL zero_len: got ack/done/rd/wr=%b want 1100",
                     {host_ack, host_done, sdram_rd_req, sdram_wr_req});
        end
        step;
        checks++;
        if ({host_ack, host_done, host_ready} !== 3'b001) begin
            failures++;
            $display("FAIL zero_len_end: got ack/done/ready=%b want 001",
                     {host_ack, host_done, host_ready});
        end
    endtask

    task automatic test_reset_mid;
        host_wr_req = 1'b1;
        host_addr   = {2'd1, 13'd9, 9'd40};
        host_len    = 9'd10;
        step;
        host_wr_req = 1'b0;
        sdram_wr_ack = 1'b1;
        step;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({host_ready, host_ack, host_done, sdram_wr_req, sdram_rd_req} !== 5'b0 ||
            {sdwr_bytes, sdrd_bytes, sys_bank, sys_row, sys_col} !== 42'd0) begin
            failures++;
            $display("FAIL reset_mid: got ctrl=%b wrb=%0d b=%0d r=%0d c=%0d want all 0",
                     {host_ready, host_ack, host_done, sdram_wr_req, sdram_rd_req},
                     sdwr_bytes, sys_bank, sys_row, sys_col);
        end
        sdram_wr_ack = 1'b0;
        step;
        rst_n = 1'b1;
        checks++;
        if (host_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_init: got ready=%b want 0", host_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step;
            checks++;
            if ({host_done, host_ready} !== 2'b01) begin
                failures++;
                $display("FAIL reset_mid_after[%0d]: got done/ready=%b want 01",
                         i, {host_done, host_ready});
            end
        end
    endtask

    initial begin
        test_reset;
        test_init;
        test_write_inpage;
        test_read_split;
        test_wrap;
        test_simul_and_zero;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
